// File: rtl/queue_drain.sv
// -----------------------------------------------------------------------------
// queue_drain
//
// Downstream consumer of the SRAM-backed byte queue. It keeps a mirror of the
// queue occupancy by watching the queue's insert strobe, and issues single-cycle
// pop strobes to the queue. It absorbs the SRAM read latency with a shift
// register of pop flags, and re-presents the bytes on a valid/ready stream
// through a 2-entry output buffer. Downstream back-pressure therefore never
// loses data.
//
// Parameters:
//   DEPTH   queue capacity in bytes (must match the queue instance)
//   LVL_W   occupancy counter width, must hold 0..DEPTH inclusive
//   RD_LAT  cycles from a q_read_o pulse to valid data on q_data_i (>= 1)
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous, active-high reset
//   q_insert_i     in   the queue's insert strobe, one byte per high cycle
//   q_read_o       out  pop strobe to the queue, one pop per high cycle
//   q_data_i       in   queue read data, valid RD_LAT cycles after a pop
//   m_valid_o      out  output byte valid
//   m_data_o       out  output byte
//   m_ready_i      in   downstream accepts (transfer on m_valid_o && m_ready_i)
//   level_o        out  bytes held in the queue, excluding bytes already popped
//   overflow_o     out  sticky: an insert was seen while level_o == DEPTH
//   drained_cnt_o  out  (only with QUEUE_DRAIN_STATS_EN) count of completed
//                       output transfers, 16 bits, wrapping
//
// Optional feature macro: QUEUE_DRAIN_STATS_EN adds drained_cnt_o.
// -----------------------------------------------------------------------------
module queue_drain #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned LVL_W  = 11,
    parameter int unsigned RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_insert_i,
    output logic             q_read_o,
    input  logic [7:0]       q_data_i,
    output logic             m_valid_o,
    output logic [7:0]       m_data_o,
    input  logic             m_ready_i,
    output logic [LVL_W-1:0] level_o,
    output logic             overflow_o
`ifdef QUEUE_DRAIN_STATS_EN
    ,
    output logic [15:0]      drained_cnt_o
`endif
);

    // Wide enough for buffered (<= 2) plus every pipe stage set.
    localparam int unsigned OccW = $clog2(RD_LAT + 4);

    // Occupancy mirror and sticky overflow flag.
    logic [LVL_W-1:0] r_level;
    logic             r_overflow;

    // Latency pipe of pop flags; bit 0 is the newest pop.
    logic [RD_LAT-1:0] r_pipe;

    // 2-entry output buffer.
    logic [7:0] r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;

    logic            w_pop;
    logic            w_wr;
    logic            w_xfer;
    logic [OccW-1:0] w_inflight;
    logic [OccW-1:0] w_occupancy;

    // ---------------------------------------------------------------------
    // Credit / pop issue
    // ---------------------------------------------------------------------
    assign w_xfer = (r_count != 2'd0) && m_ready_i;
    assign w_wr   = r_pipe[RD_LAT-1];

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + OccW'(r_pipe[i]);
        end
    end

    // A byte leaving the buffer this cycle frees its slot at the same edge.
    // Counting that slot as free is what allows one byte per cycle in steady
    // state with only two entries. The write side never overruns: buffered
    // plus in-flight is at most 2 after every edge.
    assign w_occupancy = OccW'(r_count) + w_inflight - OccW'(w_xfer);

    // The queue gives insert priority, so a pop during an insert would be lost.
    assign w_pop = (r_level != '0) && !q_insert_i && (w_occupancy < OccW'(2));

    assign q_read_o = w_pop;

    // ---------------------------------------------------------------------
    // Occupancy mirror
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (q_insert_i) begin
            if (r_level == LVL_W'(DEPTH)) begin
                // The queue drops the byte; the level holds at capacity.
                r_overflow <= 1'b1;
            end else begin
                r_level <= r_level + LVL_W'(1);
            end
        end else if (w_pop) begin
            r_level <= r_level - LVL_W'(1);
        end
    end

    assign level_o    = r_level;
    assign overflow_o = r_overflow;

    // ---------------------------------------------------------------------
    // Latency pipe
    // ---------------------------------------------------------------------
    generate
        if (RD_LAT == 1) begin : g_pipe_one
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= w_pop;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[RD_LAT-2:0], w_pop};
                end
            end
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Output buffer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= 8'h00;
            r_mem[1] <= 8'h00;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= q_data_i;
                r_wptr        <= ~r_wptr;
            end
            if (w_xfer) begin
                r_rptr <= ~r_rptr;
            end
            unique case ({w_wr, w_xfer})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign m_valid_o = (r_count != 2'd0);
    assign m_data_o  = r_mem[r_rptr];

`ifdef QUEUE_DRAIN_STATS_EN
    // ---------------------------------------------------------------------
    // Transfer statistics
    // ---------------------------------------------------------------------
    logic [15:0] r_drained;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drained <= 16'h0000;
        end else if (w_xfer) begin
            r_drained <= r_drained + 16'h0001;
        end
    end

    assign drained_cnt_o = r_drained;
`endif

    // ---------------------------------------------------------------------
    // Invariants
    // ---------------------------------------------------------------------
    a_no_buf_overrun : assert property (@(posedge clk) disable iff (rst)
        !(w_wr && !w_xfer && (r_count == 2'd2)));

    a_level_bounded : assert property (@(posedge clk) disable iff (rst)
        (r_level <= LVL_W'(DEPTH)));

    a_no_pop_on_insert : assert property (@(posedge clk) disable iff (rst)
        !(w_pop && q_insert_i));

endmodule

// File: tb/tb_queue_drain.sv
module tb_queue_drain;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned LVL_W  = 11;
    localparam int unsigned RD_LAT = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             q_insert_i;
    logic             q_read_o;
    logic [7:0]       q_data_i;
    logic             m_valid_o;
    logic [7:0]       m_data_o;
    logic             m_ready_i;
    logic [LVL_W-1:0] level_o;
    logic             overflow_o;
`ifdef QUEUE_DRAIN_STATS_EN
    logic [15:0]      drained_cnt_o;
`endif

    logic [7:0] ins_data;

    queue_drain #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W),
        .RD_LAT(RD_LAT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .q_insert_i   (q_insert_i),
        .q_read_o     (q_read_o),
        .q_data_i     (q_data_i),
        .m_valid_o    (m_valid_o),
        .m_data_o     (m_data_o),
        .m_ready_i    (m_ready_i),
        .level_o      (level_o),
        .overflow_o   (overflow_o)
`ifdef QUEUE_DRAIN_STATS_EN
        ,
        .drained_cnt_o(drained_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]       exp_q[$];   // scoreboard of bytes the DUT must emit
    logic [7:0]       sram_q[$];  // model of the external byte queue
    int               out_cyc_q[$];
    int               cyc = 0;
    int               out_cnt = 0;
    int               pop_cnt = 0;
    int               clash_cnt = 0;
    logic [LVL_W-1:0] max_level = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Queue model with one cycle of read latency.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_q.delete();
            q_data_i <= 8'h00;
        end else if (q_insert_i) begin
            if (sram_q.size() < DEPTH) sram_q.push_back(ins_data);
        end else if (q_read_o) begin
            if (sram_q.size() > 0) q_data_i <= sram_q.pop_front();
            else q_data_i <= 8'hEE;
        end
    end

    always @(posedge clk) cyc++;

    // Output monitor and scoreboard check.
    always @(negedge clk) begin
        if (!rst) begin
            if (q_read_o) pop_cnt++;
            if (q_read_o && q_insert_i) clash_cnt++;
            if (level_o > max_level) max_level = level_o;
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) check_eq("out_extra", {24'h0, m_data_o}, 32'h100);
                else check_eq("out_data", {24'h0, m_data_o}, {24'h0, exp_q.pop_front()});
                out_cyc_q.push_back(cyc);
                out_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        q_insert_i = 1'b1;
        ins_data   = b;
        if (sram_q.size() < DEPTH) exp_q.push_back(b);
        tick();
        q_insert_i = 1'b0;
    endtask

    task automatic wait_out(input int target, input int budget, input string tag);
        int k = 0;
        while (out_cnt < target && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, out_cnt, target);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int bp;
        rst        = 1'b1;
        q_insert_i = 1'b0;
        ins_data   = 8'h00;
        m_ready_i  = 1'b0;

        // Reset values
        #3;
        check_eq("rst_q_read", q_read_o, 0);
        check_eq("rst_m_valid", m_valid_o, 0);
        check_eq("rst_m_data", m_data_o, 0);
        check_eq("rst_level", level_o, 0);
        check_eq("rst_overflow", overflow_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single byte: insert in cycle 0, pop in cycle 1, valid in cycle 3
        m_ready_i = 1'b1;
        base = out_cnt;
        push_byte(8'h5A);
        at_neg();
        check_eq("single_pop_c1", q_read_o, 1);
        tick();
        at_neg();
        check_eq("single_valid_c2", m_valid_o, 0);
        check_eq("single_level_c2", level_o, 0);
        tick();
        at_neg();
        check_eq("single_valid_c3", m_valid_o, 1);
        check_eq("single_data_c3", m_data_o, 8'h5A);
        wait_out(base + 1, 5, "single_count");

        // Streaming 0x00..0x0F
        base = out_cnt;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        wait_out(base + 16, 60, "stream_count");
        check_eq("stream_no_clash", clash_cnt, 0);
        if (out_cyc_q.size() >= base + 16)
            check_eq("stream_rate", out_cyc_q[base + 15] - out_cyc_q[base], 15);
        check_eq("stream_sb_empty", exp_q.size(), 0);
        check_eq("stream_level", level_o, 0);

        // Back-pressure: 8 queued, only 2 popped
        m_ready_i = 1'b0;
        bp   = pop_cnt;
        base = out_cnt;
        for (int i = 0; i < 8; i++) push_byte(8'(8'h80 + i));
        repeat (6) tick();
        at_neg();
        check_eq("bp_pops", pop_cnt - bp, 2);
        check_eq("bp_valid", m_valid_o, 1);
        check_eq("bp_level", level_o, 6);
        check_eq("bp_head", m_data_o, 8'h80);
        tick();
        m_ready_i = 1'b1;
        wait_out(base + 8, 40, "bp_count");
        check_eq("bp_pops_all", pop_cnt - bp, 8);
        check_eq("bp_level_end", level_o, 0);
        check_eq("bp_sb_empty", exp_q.size(), 0);

        // Overflow: DEPTH+1 back-to-back inserts with no downstream
        m_ready_i = 1'b0;
        tick();
        bp = pop_cnt;
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        q_insert_i = 1'b1;
        ins_data   = 8'hF0;
        if (sram_q.size() < DEPTH) exp_q.push_back(8'hF0);
        at_neg();
        check_eq("ovf_before", overflow_o, 0);
        check_eq("ovf_level_full", level_o, DEPTH);
        check_eq("ovf_no_pop_on_ins", q_read_o, 0);
        tick();
        q_insert_i = 1'b0;
        at_neg();
        check_eq("ovf_set", overflow_o, 1);
        check_eq("ovf_level_sat", level_o, DEPTH);
        repeat (4) tick();
        at_neg();
        check_eq("ovf_level_after_pops", level_o, DEPTH - 2);
        check_eq("ovf_pops", pop_cnt - bp, 2);
        check_eq("ovf_sticky", overflow_o, 1);
        check_eq("ovf_max_level", max_level, DEPTH);

        // Asynchronous reset mid-cycle with the buffer full
        check_eq("prerst_valid", m_valid_o, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_valid", m_valid_o, 0);
        check_eq("arst_level", level_o, 0);
        check_eq("arst_q_read", q_read_o, 0);
        check_eq("arst_overflow", overflow_o, 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
`ifdef QUEUE_DRAIN_STATS_EN
        check_eq("stats_rst", drained_cnt_o, 16'h0000);
`endif
        base = out_cnt;
        m_ready_i = 1'b1;
        push_byte(8'h11);
        wait_out(base + 1, 10, "arst_first");
        repeat (5) tick();
        check_eq("arst_only_one", out_cnt - base, 1);
        check_eq("arst_sb_empty", exp_q.size(), 0);

`ifdef QUEUE_DRAIN_STATS_EN
        // Counter wrap: reach 0xFFFE transfers, then 2 more
        begin
            int total;
            int n;
            total = 1;
            while (total < 65534) begin
                n = (65534 - total > 256) ? 256 : 65534 - total;
                base = out_cnt;
                for (int i = 0; i < n; i++) push_byte(8'(total + i));
                wait_out(base + n, n + 20, "stats_burst");
                total += n;
            end
            at_neg();
            check_eq("stats_fffe", drained_cnt_o, 16'hFFFE);
            base = out_cnt;
            push_byte(8'hA1);
            push_byte(8'hA2);
            wait_out(base + 2, 20, "stats_last");
            at_neg();
            check_eq("stats_wrap", drained_cnt_o, 16'h0000);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
